// File: rtl/imem_fetch_if.sv
// Fetch-side bundle: instruction-memory read port, redirect input and the
// valid/ready instruction stream toward decode.
interface imem_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              fault;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_addr,
    output instr_valid,
    input  instr_ready,
    output instr_data, instr_pc, fault
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_addr,
    input  instr_valid,
    output instr_ready,
    input  instr_data, instr_pc, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues synchronous memory reads and
// buffers returned words in a small prefetch FIFO presented to decode.
module imem_fetch_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(10)
) (
  input  logic         clk,
  input  logic         rst,
  imem_fetch_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [CNT_W-1:0]   cnt_q;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0]  fifo_data [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc   [DEPTH];

  logic               redirect, head_vld, pop, push;
  logic               space, issue_due, oob, issue;
  logic [CNT_W-1:0]   occ;

  // Occupancy counts words buffered plus the one still in flight, net of this cycle's pop.
  always_comb begin
    redirect  = bus.redirect_valid;
    head_vld  = (cnt_q != '0);
    pop       = head_vld & ~redirect & bus.instr_ready;
    push      = vld_p1 & ~redirect;
    occ       = cnt_q + CNT_W'(vld_p1) - CNT_W'(pop);
    space     = (occ < DEPTH_C);
    issue_due = (state_q == S_RUN) & ~redirect & space;
    oob       = (pc_q > LAST_ADDR);
    issue     = issue_due & ~oob & ~rst;
  end

  always_comb begin
    state_d = state_q;
    if (redirect)
      state_d = S_RUN;
    else if (issue_due && oob)
      state_d = S_FAULT;
  end

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = head_vld & ~redirect;
  assign bus.instr_data  = head_vld ? fifo_data[rd_ptr_q] : '0;
  assign bus.instr_pc    = head_vld ? fifo_pc[rd_ptr_q]   : '0;
  assign bus.fault       = (state_q == S_FAULT);

  // Stage p0 -> p1: issue registered; a redirect kills the returning read by never pushing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      vld_p1   <= 1'b0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      if (redirect) begin
        pc_q     <= bus.redirect_addr;
        cnt_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (issue) pc_q <= pc_q + ADDR_W'(1);
        if (push)  wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Stage p1 -> FIFO: returned word captured with the address it was fetched from.
  always_ff @(posedge clk) begin
    addr_p1 <= pc_q;
    if (push) begin
      fifo_data[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc[wr_ptr_q]   <= addr_p1;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == DEPTH_C));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and randomized checks of the fetch sequencer against a word-addressed
// memory model where mem[k] = k + 0x100.
module tb_imem_fetch_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam logic [31:0] LAST = 32'd10;

  typedef struct {
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] got [$];

  always #5 clk = ~clk;

  imem_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RESET_PC(32'd0), .LAST_ADDR(LAST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk)
    bus.imem_rdata <= bus.imem_en ? bus.imem_addr + 32'h100 : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic rv, input logic [31:0] ra);
    bus.instr_ready    = r;
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra;
  endtask

  // Settle combinational outputs, then apply checks that hold on every cycle.
  task automatic settle_mon();
    #1;
    if (bus.imem_en) chk("en_addr_in_range", bus.imem_addr <= LAST, 1);
    if (bus.instr_valid) chk("data_matches_pc", bus.instr_data, bus.instr_pc + 32'h100);
    if (bus.redirect_valid) chk("no_valid_on_redirect", bus.instr_valid, 0);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_cycle();
    if (bus.instr_valid && bus.instr_ready) got.push_back(bus.instr_pc);
    clk_edge();
  endtask

  task automatic run_cycle(input logic r, input logic rv, input logic [31:0] ra);
    set_in(r, rv, ra);
    settle_mon();
    finish_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0);
    repeat (2) clk_edge();
    #1;
    chk("rst_en", bus.imem_en, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_fault", bus.fault, 0);
    rst = 1'b0;
    got.delete();
  endtask

  initial begin
    vec_t tv [12];
    logic [31:0] exp3 [3];
    logic [31:0] exp5 [3];
    logic [31:0] exp_next;
    logic        prev_stall;
    logic [31:0] prev_pc;
    int          deliveries;
    logic        r, rv;
    logic [31:0] ra;

    tv[0]  = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
    tv[1]  = '{1'b1, 1'b1, 32'd1, 1'b0, 32'd0};
    tv[2]  = '{1'b1, 1'b1, 32'd2, 1'b1, 32'd0};
    tv[3]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd1};
    tv[4]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd1};
    tv[5]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd1};
    tv[6]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd1};
    tv[7]  = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd1};
    tv[8]  = '{1'b1, 1'b1, 32'd3, 1'b1, 32'd1};
    tv[9]  = '{1'b1, 1'b1, 32'd4, 1'b1, 32'd2};
    tv[10] = '{1'b1, 1'b1, 32'd5, 1'b1, 32'd3};
    tv[11] = '{1'b1, 1'b1, 32'd6, 1'b1, 32'd4};

    // Streaming from reset, then a stall filling the FIFO, then resume.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(tv[i].rdy, 0, 0);
      settle_mon();
      chk($sformatf("tv%0d_en", i), bus.imem_en, tv[i].en);
      if (tv[i].en) chk($sformatf("tv%0d_addr", i), bus.imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), bus.instr_valid, tv[i].vld);
      if (tv[i].vld) chk($sformatf("tv%0d_pc", i), bus.instr_pc, tv[i].pc);
      chk($sformatf("tv%0d_fault", i), bus.fault, 0);
      finish_cycle();
    end

    // Redirect to 7 with one read in flight and a word buffered.
    do_reset();
    for (int c = 0; c < 3; c++) run_cycle(1, 0, 0);
    set_in(1, 1, 32'd7);
    settle_mon();
    chk("t3_redir_valid", bus.instr_valid, 0);
    chk("t3_redir_en", bus.imem_en, 0);
    finish_cycle();
    set_in(1, 0, 0);
    settle_mon();
    chk("t3_en7", bus.imem_en, 1);
    chk("t3_addr7", bus.imem_addr, 7);
    chk("t3_c4_valid", bus.instr_valid, 0);
    finish_cycle();
    settle_mon();
    chk("t3_addr8", bus.imem_addr, 8);
    chk("t3_c5_valid", bus.instr_valid, 0);
    finish_cycle();
    settle_mon();
    chk("t3_c6_valid", bus.instr_valid, 1);
    chk("t3_c6_pc", bus.instr_pc, 7);
    finish_cycle();
    run_cycle(1, 0, 0);
    exp3[0] = 32'd0; exp3[1] = 32'd7; exp3[2] = 32'd8;
    chk("t3_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("t3_seq%0d", i), got[i], exp3[i]);

    // Redirect while stalled with a full FIFO.
    do_reset();
    for (int c = 0; c < 4; c++) run_cycle(0, 0, 0);
    set_in(1, 1, 32'd7);
    settle_mon();
    chk("t3b_redir_valid", bus.instr_valid, 0);
    finish_cycle();
    run_cycle(1, 0, 0);
    run_cycle(1, 0, 0);
    set_in(1, 0, 0);
    settle_mon();
    chk("t3b_pc7", bus.instr_pc, 7);
    chk("t3b_valid", bus.instr_valid, 1);
    finish_cycle();

    // Run off the end of memory into FAULT, then recover by redirect.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      set_in(1, 0, 0);
      settle_mon();
      if (c == 11) begin
        chk("t4_c11_en", bus.imem_en, 0);
        chk("t4_c11_fault", bus.fault, 0);
      end
      if (c == 12) begin
        chk("t4_c12_fault", bus.fault, 1);
        chk("t4_c12_pc", bus.instr_pc, 10);
      end
      finish_cycle();
    end
    chk("t4_fault_held", bus.fault, 1);
    chk("t4_count", got.size(), 11);
    for (int i = 0; i < got.size() && i < 11; i++) chk($sformatf("t4_seq%0d", i), got[i], i);
    set_in(1, 1, 32'd2);
    settle_mon();
    chk("t4_redir_fault", bus.fault, 1);
    finish_cycle();
    set_in(1, 0, 0);
    settle_mon();
    chk("t4_fault_clr", bus.fault, 0);
    chk("t4_addr2", bus.imem_addr, 2);
    chk("t4_en2", bus.imem_en, 1);
    finish_cycle();
    run_cycle(1, 0, 0);
    set_in(1, 0, 0);
    settle_mon();
    chk("t4_pc2", bus.instr_pc, 2);
    finish_cycle();

    // Back-to-back redirects: only the last target is fetched.
    do_reset();
    for (int c = 0; c < 3; c++) run_cycle(1, 0, 0);
    run_cycle(1, 1, 32'd4);
    set_in(1, 1, 32'd9);
    settle_mon();
    chk("t5_en_redir2", bus.imem_en, 0);
    finish_cycle();
    for (int c = 0; c < 6; c++) run_cycle(1, 0, 0);
    exp5[0] = 32'd0; exp5[1] = 32'd9; exp5[2] = 32'd10;
    chk("t5_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("t5_seq%0d", i), got[i], exp5[i]);

    // Reset in mid-stream.
    do_reset();
    for (int c = 0; c < 4; c++) run_cycle(1, 0, 0);
    rst = 1'b1;
    clk_edge();
    #1;
    chk("t5r_en", bus.imem_en, 0);
    chk("t5r_addr", bus.imem_addr, 0);
    chk("t5r_valid", bus.instr_valid, 0);
    chk("t5r_data", bus.instr_data, 0);
    chk("t5r_pc", bus.instr_pc, 0);
    chk("t5r_fault", bus.fault, 0);
    clk_edge();
    rst = 1'b0;
    got.delete();
    set_in(1, 0, 0);
    settle_mon();
    chk("t5r_restart_en", bus.imem_en, 1);
    chk("t5r_restart_addr", bus.imem_addr, 0);
    finish_cycle();
    run_cycle(1, 0, 0);
    set_in(1, 0, 0);
    settle_mon();
    chk("t5r_first_pc", bus.instr_pc, 0);
    chk("t5r_first_valid", bus.instr_valid, 1);
    finish_cycle();

    // Random ready/redirect against a sequential-PC stream model.
    do_reset();
    exp_next   = 32'd0;
    prev_stall = 1'b0;
    prev_pc    = 32'd0;
    deliveries = 0;
    for (int c = 0; c < 10000; c++) begin
      r  = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 15) == 0);
      ra = $urandom_range(0, 12);
      set_in(r, rv, ra);
      settle_mon();
      if (prev_stall && !rv) begin
        chk("rand_hold_valid", bus.instr_valid, 1);
        chk("rand_hold_pc", bus.instr_pc, prev_pc);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        chk("rand_seq_pc", bus.instr_pc, exp_next);
        exp_next = exp_next + 1;
        deliveries++;
      end
      if (rv) exp_next = ra;
      prev_stall = bus.instr_valid & ~bus.instr_ready;
      prev_pc    = bus.instr_pc;
      clk_edge();
    end
    chk("rand_liveness", deliveries > 500, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
